// File: rtl/nav_cmd_gen.sv
// nav_cmd_gen: heading-error source and align/ramp/cruise/ramp-down move sequencer for the PID block.
module nav_cmd_gen #(
  parameter logic [9:0]  FRWRD_INC  = 10'd16,
  parameter logic [9:0]  FRWRD_DEC  = 10'd32,
  parameter logic [9:0]  MAX_FRWRD  = 10'h2A0,
  parameter logic [11:0] ERR_THRESH = 12'd48,
  parameter int          DIST_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_vld_i,
  input  logic              cmd_move_i,
  input  logic [11:0]       cmd_hdg_i,
  input  logic [DIST_W-1:0] cmd_dist_i,
  input  logic              hdg_vld_i,
  input  logic [11:0]       heading_i,
  input  logic              cntr_pulse_i,
  output logic              moving_o,
  output logic [9:0]        frwrd_o,
  output logic [11:0]       error_o,
  output logic              err_vld_o,
  output logic              busy_o,
  output logic              done_o
);
  typedef enum logic [2:0] {IDLE, ALIGN, RAMP_UP, CRUISE, RAMP_DOWN} state_t;
  state_t              state_q, state_d;
  logic [11:0]         dsrd_q, dsrd_d, error_q;
  logic [DIST_W-1:0]   cnt_q, cnt_d, tgt_q, tgt_d;
  logic [9:0]          frwrd_q, frwrd_d;
  logic                done_q, done_d, err_vld_q;
  logic [11:0]         diff, mag;
  logic [10:0]         sum;
  logic                aligned, abort, start, term;
  logic [DIST_W-1:0]   cnt_inc;
  assign diff    = heading_i - dsrd_q;
  assign mag     = diff[11] ? -diff : diff;
  assign aligned = mag < ERR_THRESH;
  assign abort   = cmd_vld_i & ~cmd_move_i;
  assign start   = cmd_vld_i & cmd_move_i;
  assign term    = cnt_q == tgt_q;
  assign sum     = {1'b0, frwrd_q} + {1'b0, FRWRD_INC};
  assign cnt_inc = cntr_pulse_i && !(&cnt_q) ? cnt_q + DIST_W'(1) : cnt_q;
  always_comb begin
    state_d = state_q;
    dsrd_d  = dsrd_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    frwrd_d = frwrd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        frwrd_d = '0;
        if (start) begin
          dsrd_d  = cmd_hdg_i;
          tgt_d   = cmd_dist_i;
          cnt_d   = '0;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (abort) state_d = RAMP_DOWN;
        else if (hdg_vld_i && aligned) state_d = (tgt_q == '0) ? RAMP_DOWN : RAMP_UP;
      end
      RAMP_UP: begin
        if (abort || term) state_d = RAMP_DOWN;
        else begin
          cnt_d = cnt_inc;
          if (hdg_vld_i) begin
            frwrd_d = (sum >= {1'b0, MAX_FRWRD}) ? MAX_FRWRD : sum[9:0];
            state_d = (sum >= {1'b0, MAX_FRWRD}) ? CRUISE : RAMP_UP;
          end
        end
      end
      CRUISE: begin
        frwrd_d = MAX_FRWRD;
        if (abort || term) state_d = RAMP_DOWN;
        else cnt_d = cnt_inc;
      end
      RAMP_DOWN: begin
        // floor at zero rather than letting the subtraction wrap
        if (frwrd_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (hdg_vld_i) frwrd_d = (frwrd_q > FRWRD_DEC) ? frwrd_q - FRWRD_DEC : '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dsrd_q    <= '0;
      cnt_q     <= '0;
      tgt_q     <= '0;
      frwrd_q   <= '0;
      done_q    <= 1'b0;
      error_q   <= '0;
      err_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dsrd_q    <= dsrd_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      frwrd_q   <= frwrd_d;
      done_q    <= done_d;
      err_vld_q <= hdg_vld_i;
      if (hdg_vld_i) error_q <= diff;
    end
  end
  assign moving_o  = state_q != IDLE;
  assign busy_o    = state_q != IDLE;
  assign frwrd_o   = frwrd_q;
  assign error_o   = error_q;
  assign err_vld_o = err_vld_q;
  assign done_o    = done_q;
endmodule

// File: tb/tb_nav_cmd_gen.sv
// tb_nav_cmd_gen: table-driven error path plus scripted move sequences, error scoreboard on err_vld.
module tb_nav_cmd_gen;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_vld = 1'b0, cmd_move = 1'b0, hdg_vld = 1'b0, cntr = 1'b0;
  logic [11:0] cmd_hdg = '0, heading = '0;
  logic [3:0]  cmd_dist = '0;
  logic        moving, err_vld, busy, done;
  logic [9:0]  frwrd;
  logic [11:0] error;
  logic [11:0] sb[$];
  logic [11:0] dsrd_m = '0;
  int ncmp = 0, nerr = 0;
  typedef struct {logic [11:0] h; logic [11:0] e;} vec_t;
  vec_t tbl[4];

  nav_cmd_gen dut (
    .clk(clk), .rst(rst), .cmd_vld_i(cmd_vld), .cmd_move_i(cmd_move), .cmd_hdg_i(cmd_hdg),
    .cmd_dist_i(cmd_dist), .hdg_vld_i(hdg_vld), .heading_i(heading), .cntr_pulse_i(cntr),
    .moving_o(moving), .frwrd_o(frwrd), .error_o(error), .err_vld_o(err_vld),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && err_vld) begin
      if (sb.size() == 0) chk("err_unexpected", 1, 0);
      else chk("err_sb", error, sb.pop_front());
    end

  task automatic step(input logic hv, input logic [11:0] h, input logic cp);
    hdg_vld = hv; heading = h; cntr = cp;
    if (hv) sb.push_back(h - dsrd_m);
    @(posedge clk); #1;
    hdg_vld = 1'b0; cntr = 1'b0; cmd_vld = 1'b0;
  endtask

  task automatic cmd(input logic mv, input logic [11:0] h, input logic [3:0] d, input logic acc);
    cmd_vld = 1'b1; cmd_move = mv; cmd_hdg = h; cmd_dist = d;
    @(posedge clk); #1;
    cmd_vld = 1'b0;
    if (acc) dsrd_m = h;
  endtask

  task automatic wait_done(input string n);
    int k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 8);
    chk({n, "_done"}, done, 1);
    chk({n, "_moving"}, moving, 0);
    chk({n, "_frwrd"}, frwrd, 0);
    @(negedge clk);
    chk({n, "_done_1cyc"}, done, 0);
  endtask

  initial begin
    tbl[0] = '{12'd100, 12'h064};
    tbl[1] = '{12'hFFB, 12'hFFB};
    tbl[2] = '{12'h7FF, 12'h7FF};
    tbl[3] = '{12'h800, 12'h800};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_frwrd", frwrd, 0); chk("rst_moving", moving, 0); chk("rst_busy", busy, 0);
    chk("rst_errvld", err_vld, 0); chk("rst_done", done, 0); chk("rst_error", error, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      hdg_vld = 1'b1; heading = tbl[i].h;
      sb.push_back(tbl[i].e);
      @(posedge clk); #1;
      hdg_vld = 1'b0;
      chk("tbl_errvld", err_vld, 1);
    end
    @(posedge clk); #1;
    chk("errvld_drop", err_vld, 0);

    cmd(1'b0, 12'h0, 4'd0, 1'b0);
    chk("idle_abort_busy", busy, 0); chk("idle_abort_done", done, 0);

    cmd(1'b1, 12'd1, 4'd0, 1'b1);
    step(1'b1, 12'h800, 1'b0);
    chk("wrap_align_busy", busy, 1);
    cmd(1'b0, 12'h0, 4'd0, 1'b0);
    wait_done("abort_align");

    cmd(1'b1, 12'd0, 4'd3, 1'b1);
    step(1'b1, 12'd0, 1'b0);
    chk("align_exit_frwrd", frwrd, 0);
    for (int i = 0; i < 42; i++) begin
      step(1'b1, 12'd0, 1'b0);
      chk("ramp_up", frwrd, (i + 1) * 16);
    end
    step(1'b1, 12'd0, 1'b0);
    chk("cruise_hold", frwrd, 10'h2A0);
    repeat (3) step(1'b0, 12'd0, 1'b1);
    repeat (2) step(1'b0, 12'd0, 1'b0);
    chk("rd_entry_frwrd", frwrd, 10'h2A0);
    for (int i = 0; i < 21; i++) begin
      step(1'b1, 12'd0, 1'b0);
      chk("ramp_down", frwrd, 672 - (i + 1) * 32);
    end
    chk("rd_moving", moving, 1);
    wait_done("move3");

    cmd(1'b1, 12'd0, 4'd2, 1'b1);
    step(1'b1, 12'd200, 1'b0);
    step(1'b1, 12'hF38, 1'b0);
    chk("align200_frwrd", frwrd, 0); chk("align200_busy", busy, 1);
    step(1'b1, 12'd40, 1'b0);
    chk("align40_frwrd", frwrd, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 12'd40, 1'b0);
      chk("ru40", frwrd, (i + 1) * 16);
    end
    cmd_vld = 1'b1; cmd_move = 1'b0;
    step(1'b1, 12'd40, 1'b1);
    chk("abort_no_inc", frwrd, 48);
    cmd_vld = 1'b1; cmd_move = 1'b0;
    step(1'b1, 12'd40, 1'b0);
    chk("abort_rd_dec", frwrd, 16);
    step(1'b1, 12'd40, 1'b0);
    chk("rd_floor", frwrd, 0); chk("rd_floor_moving", moving, 1);
    wait_done("abort_ru");

    cmd(1'b1, 12'h100, 4'd0, 1'b1);
    cmd(1'b1, 12'h500, 4'd5, 1'b0);
    step(1'b1, 12'h10A, 1'b0);
    chk("dist0_frwrd", frwrd, 0);
    wait_done("dist0");

    cmd(1'b1, 12'd0, 4'd15, 1'b1);
    for (int i = 0; i < 44; i++) step(1'b1, 12'd0, 1'b0);
    chk("pre_rst_frwrd", frwrd, 10'h2A0); chk("pre_rst_errvld", err_vld, 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_frwrd", frwrd, 0); chk("arst_moving", moving, 0);
    chk("arst_busy", busy, 0); chk("arst_errvld", err_vld, 0); chk("arst_done", done, 0);
    sb.delete();
    dsrd_m = '0;
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_done", done, 0);
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
